logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//   Parametrised, registered bitwise logic unit with valid/ready handshakes. Each beat computes
//   one of eight two-operand bitwise ops on WIDTH-bit operands. Multi-beat packets are AND-folded
//   into a single result, so chained predicates (e.g. a set of implications) reduce to one word.
//   Sits between operand sources and the result/branch-condition consumers in the datapath.
// PARAMETERS
//   WIDTH  32  operand/result width in bits, >= 1
//   CNTW   8   width of the beat counter; saturates at 2**CNTW-1
// PORTS
//   clk        in   1             rising-edge clock
//   reset      in   1             asynchronous, active-high reset
//   in_valid   in   1             operand beat valid
//   in_ready   out  1             unit can accept a beat this cycle
//   op         in   3             000 AND, 001 OR, 010 XOR, 011 NOR, 100 IMP (~a|b), 101 NIMP (a&~b), 110 XNOR, 111 PASS_A
//   a          in   WIDTH         operand A
//   b          in   WIDTH         operand B
//   last       in   1             final beat of packet
//   out_valid  out  1             result valid
//   out_ready  in   1             consumer accepts result
//   y          out  WIDTH         folded result
//   zero       out  1             y == 0
//   beats      out  CNTW          number of beats in the packet that produced y
// BEHAVIOUR
//   - Transfer: a beat is accepted when in_valid && in_ready. A result is taken when out_valid && out_ready.
//   - in_ready = !out_valid || out_ready. It does not depend on last, op or data.
//   - Per beat: r = f(op, a, b), where f is bitwise as listed under op.
//   - States:
//       IDLE  : no partial result held.
//       ACCUM : partial result acc and count cnt held.
//   - Accepted beat, last = 0:
//       IDLE  -> ACCUM, acc <= r, cnt <= 1.
//       ACCUM -> ACCUM, acc <= acc & r, cnt <= sat(cnt + 1).
//   - Accepted beat, last = 1:
//       y <= (state == ACCUM ? acc & r : r).
//       beats <= (state == ACCUM ? sat(cnt + 1) : 1).
//       out_valid <= 1. Next state is IDLE.
//   - Latency: result registered 1 cycle after the last beat is accepted. Throughput is 1 beat per cycle.
//   - Simultaneous drain and fill: if out_valid && out_ready while a last beat is accepted, the new
//     result replaces the old one and out_valid stays 1.
//   - Drain only: out_valid && out_ready with no last beat accepted -> out_valid <= 0. y, beats and
//     zero hold their values.
//   - Backpressure: y, zero and beats are stable while out_valid && !out_ready.
//   - Saturation: cnt and beats stop at 2**CNTW-1. No wrap.
//   - zero is registered together with y.
//   - Reset (asynchronous, any time, including mid-packet): state = IDLE, acc = 0, cnt = 0,
//     out_valid = 0, y = 0, zero = 1, beats = 0. Any partial packet is discarded.
// CONFIGURATION
//   LOGIC_UNIT_POPCNT_EN
//     Defined: adds output port popcnt [$clog2(WIDTH+1)-1:0], the number of 1 bits in y.
//       It is registered in the same cycle as y, reset value 0, and held under backpressure.
//     Undefined: the popcnt port and its logic are absent. All other behaviour is identical.
// TESTING
//   1. a=32'hF0F0_F0F0, b=32'h0F0F_0000, op=100, last=1
//        -> next cycle out_valid=1, y=32'h0F0F_0F0F, beats=1, zero=0.
//   2. 3-beat IMP packet with (a,b) = (1,1), (1,1), (1,0) on bit 0, other bits a=0
//        -> y=32'hFFFF_FFFE, beats=3.
//   3. out_ready=0 while out_valid, in_valid=1 held
//        -> in_ready=0, y stable for 5 cycles.
//      Raise out_ready with a last beat present
//        -> new y the next cycle, out_valid stays 1.
//   4. reset pulsed asynchronously after 2 non-last beats
//        -> out_valid=0, zero=1 immediately.
//      Then a single beat op=000, a=b=32'h1
//        -> y=32'h1, beats=1.
//   5. CNTW=2, 6-beat packet of op=111, a=32'hFFFF_FFFF
//        -> beats=3 (saturated), y=32'hFFFF_FFFF.
//   6. With LOGIC_UNIT_POPCNT_EN, op=010, a=32'hFFFF_0000, b=32'h00FF_0000
//        -> y=32'hFF00_0000, popcnt=8.

Source files
------------

// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if: operand/result handshake bundle for logic_unit_pipe.
//   slave  : the unit (consumes in_*/op/a/b/last/out_ready, drives in_ready/out_valid/y/zero/beats)
//   master : the operand source and result consumer, with the opposite directions
//   Macro LOGIC_UNIT_POPCNT_EN adds popcnt (number of 1 bits in y).
interface logic_unit_pipe_if #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 8
);
  logic             in_valid, in_ready, last;
  logic [2:0]       op;
  logic [WIDTH-1:0] a, b, y;
  logic             out_valid, out_ready, zero;
  logic [CNTW-1:0]  beats;
`ifdef LOGIC_UNIT_POPCNT_EN
  logic [$clog2(WIDTH+1)-1:0] popcnt;
  modport slave (input in_valid, op, a, b, last, out_ready,
                 output in_ready, out_valid, y, zero, beats, popcnt);
  modport master (output in_valid, op, a, b, last, out_ready,
                  input in_ready, out_valid, y, zero, beats, popcnt);
`else
  modport slave (input in_valid, op, a, b, last, out_ready,
                 output in_ready, out_valid, y, zero, beats);
  modport master (output in_valid, op, a, b, last, out_ready,
                  input in_ready, out_valid, y, zero, beats);
`endif
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise logic unit that AND-folds multi-beat packets into one result.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : logic_unit_pipe_if.slave (in_valid/in_ready, op, a, b, last, out_valid/out_ready, y, zero, beats)
//   Macro LOGIC_UNIT_POPCNT_EN adds bus.popcnt, registered alongside y.
module logic_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 8
) (
  input logic              clk,
  input logic              reset,
  logic_unit_pipe_if.slave bus
);
  typedef enum logic {IDLE, ACCUM} state_t;
  localparam logic [CNTW-1:0] CMAX = '1;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, y_q, y_d, r, fold;
  logic [CNTW-1:0]  cnt_q, cnt_d, beats_q, beats_d, cnt_nx;
  logic             vld_q, vld_d, zero_q, zero_d, take, fin;
`ifdef LOGIC_UNIT_POPCNT_EN
  localparam int PW = $clog2(WIDTH+1);
  logic [PW-1:0]    pc_q, pc_d;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      y_q     <= '0;
      zero_q  <= 1'b1;
      beats_q <= '0;
`ifdef LOGIC_UNIT_POPCNT_EN
      pc_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      beats_q <= beats_d;
`ifdef LOGIC_UNIT_POPCNT_EN
      pc_q    <= pc_d;
`endif
    end
  end
  always_comb begin
    case (bus.op)
      3'b000:  r = bus.a & bus.b;
      3'b001:  r = bus.a | bus.b;
      3'b010:  r = bus.a ^ bus.b;
      3'b011:  r = ~(bus.a | bus.b);
      3'b100:  r = ~bus.a | bus.b;
      3'b101:  r = bus.a & ~bus.b;
      3'b110:  r = ~(bus.a ^ bus.b);
      default: r = bus.a;
    endcase
  end
  // fin captures a finished packet; a drain without fin only drops out_valid, holding y/zero/beats
  always_comb begin
    take    = bus.in_valid && (!vld_q || bus.out_ready);
    fin     = take && bus.last;
    fold    = state_q == ACCUM ? acc_q & r : r;
    cnt_nx  = state_q == ACCUM ? (cnt_q == CMAX ? cnt_q : cnt_q + 1'b1) : CNTW'(1);
    state_d = take ? (bus.last ? IDLE : ACCUM) : state_q;
    acc_d   = take && !bus.last ? fold : acc_q;
    cnt_d   = take && !bus.last ? cnt_nx : cnt_q;
    vld_d   = fin || (vld_q && !bus.out_ready);
    y_d     = fin ? fold : y_q;
    zero_d  = fin ? ~|fold : zero_q;
    beats_d = fin ? cnt_nx : beats_q;
`ifdef LOGIC_UNIT_POPCNT_EN
    pc_d    = fin ? PW'($countones(fold)) : pc_q;
`endif
  end
  always_comb begin
    bus.in_ready  = !vld_q || bus.out_ready;
    bus.out_valid = vld_q;
    bus.y         = y_q;
    bus.zero      = zero_q;
    bus.beats     = beats_q;
`ifdef LOGIC_UNIT_POPCNT_EN
    bus.popcnt    = pc_q;
`endif
  end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed self-checking bench for logic_unit_pipe (default and CNTW=2 instances).
module tb_logic_unit_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  logic_unit_pipe_if #(.WIDTH(32), .CNTW(8)) bi();
  logic_unit_pipe_if #(.WIDTH(32), .CNTW(2)) bs();
  logic_unit_pipe #(.WIDTH(32), .CNTW(8)) dut (.clk(clk), .reset(reset), .bus(bi));
  logic_unit_pipe #(.WIDTH(32), .CNTW(2)) dut_sat (.clk(clk), .reset(reset), .bus(bs));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv, input logic l);
    bi.in_valid = v;
    bi.op = o;
    bi.a = av;
    bi.b = bv;
    bi.last = l;
  endtask
  task automatic test_reset;
    #12;
    n_chk++; if (bi.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", bi.out_valid); end
    n_chk++; if (bi.zero !== 1'b1) begin n_fail++; $display("FAIL rst_zero got %b exp 1", bi.zero); end
    n_chk++; if (bi.y !== 32'h0) begin n_fail++; $display("FAIL rst_y got %h exp 0", bi.y); end
    n_chk++; if (bi.beats !== 8'd0) begin n_fail++; $display("FAIL rst_beats got %0d exp 0", bi.beats); end
    n_chk++; if (bi.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", bi.in_ready); end
`ifdef LOGIC_UNIT_POPCNT_EN
    n_chk++; if (bi.popcnt !== 6'd0) begin n_fail++; $display("FAIL rst_popcnt got %0d exp 0", bi.popcnt); end
`endif
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask
  task automatic test_single;
    bi.out_ready = 1'b0;
    drive(1'b1, 3'b100, 32'hF0F0_F0F0, 32'h0F0F_0000, 1'b1);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    n_chk++; if (bi.out_valid !== 1'b1) begin n_fail++; $display("FAIL t1_out_valid got %b exp 1", bi.out_valid); end
    n_chk++; if (bi.y !== 32'h0F0F_0F0F) begin n_fail++; $display("FAIL t1_y got %h exp 0f0f0f0f", bi.y); end
    n_chk++; if (bi.beats !== 8'd1) begin n_fail++; $display("FAIL t1_beats got %0d exp 1", bi.beats); end
    n_chk++; if (bi.zero !== 1'b0) begin n_fail++; $display("FAIL t1_zero got %b exp 0", bi.zero); end
    bi.out_ready = 1'b1;
    tick();
    n_chk++; if (bi.out_valid !== 1'b0) begin n_fail++; $display("FAIL t1_drain_valid got %b exp 0", bi.out_valid); end
    n_chk++; if (bi.y !== 32'h0F0F_0F0F) begin n_fail++; $display("FAIL t1_drain_y_hold got %h exp 0f0f0f0f", bi.y); end
  endtask
  task automatic test_imp_packet;
    bi.out_ready = 1'b1;
    drive(1'b1, 3'b100, 32'h1, 32'h1, 1'b0);
    tick();
    n_chk++; if (bi.out_valid !== 1'b0) begin n_fail++; $display("FAIL t2_mid_valid got %b exp 0", bi.out_valid); end
    tick();
    drive(1'b1, 3'b100, 32'h1, 32'h0, 1'b1);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    n_chk++; if (bi.out_valid !== 1'b1) begin n_fail++; $display("FAIL t2_out_valid got %b exp 1", bi.out_valid); end
    n_chk++; if (bi.y !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL t2_y got %h exp fffffffe", bi.y); end
    n_chk++; if (bi.beats !== 8'd3) begin n_fail++; $display("FAIL t2_beats got %0d exp 3", bi.beats); end
    tick();
  endtask
  task automatic test_back_to_back;
    logic [31:0] exp_y [8] = '{32'h8888_8888, 32'hEEEE_EEEE, 32'h6666_6666, 32'h1111_1111,
                               32'hBBBB_BBBB, 32'h4444_4444, 32'h9999_9999, 32'hCCCC_CCCC};
    bi.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 32'hCCCC_CCCC, 32'hAAAA_AAAA, 1'b1);
      tick();
      n_chk++; if (bi.y !== exp_y[i] || bi.out_valid !== 1'b1) begin n_fail++; $display("FAIL ops_%0d got y=%h v=%b exp y=%h v=1", i, bi.y, bi.out_valid, exp_y[i]); end
    end
    drive(1'b1, 3'b010, 32'h1234_5678, 32'h1234_5678, 1'b1);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    n_chk++; if (bi.zero !== 1'b1 || bi.y !== 32'h0) begin n_fail++; $display("FAIL xor_zero got zero=%b y=%h exp zero=1 y=0", bi.zero, bi.y); end
    tick();
  endtask
  task automatic test_backpressure;
    bi.out_ready = 1'b0;
    drive(1'b1, 3'b111, 32'h1234_5678, 32'h0, 1'b1);
    tick();
    drive(1'b1, 3'b000, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (bi.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d got %b exp 0", i, bi.in_ready); end
      n_chk++; if (bi.y !== 32'h1234_5678 || bi.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_%0d got y=%h v=%b exp y=12345678 v=1", i, bi.y, bi.out_valid); end
      tick();
    end
    bi.out_ready = 1'b1;
    #1;
    n_chk++; if (bi.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", bi.in_ready); end
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    n_chk++; if (bi.y !== 32'h0F00_0F00 || bi.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_refill got y=%h v=%b exp y=0f000f00 v=1", bi.y, bi.out_valid); end
    tick();
    n_chk++; if (bi.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b exp 0", bi.out_valid); end
  endtask
  task automatic test_async_reset;
    bi.out_ready = 1'b0;
    drive(1'b1, 3'b111, 32'h5A5A_5A5A, 32'h0, 1'b1);
    tick();
    bi.out_ready = 1'b1;
    drive(1'b1, 3'b000, 32'h2, 32'h2, 1'b0);
    tick();
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    n_chk++; if (bi.out_valid !== 1'b0 || bi.zero !== 1'b1) begin n_fail++; $display("FAIL arst_flags got v=%b zero=%b exp v=0 zero=1", bi.out_valid, bi.zero); end
    n_chk++; if (bi.y !== 32'h0 || bi.beats !== 8'd0) begin n_fail++; $display("FAIL arst_regs got y=%h beats=%0d exp y=0 beats=0", bi.y, bi.beats); end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 3'b000, 32'h1, 32'h1, 1'b1);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    n_chk++; if (bi.y !== 32'h1 || bi.beats !== 8'd1 || bi.out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_after got y=%h beats=%0d v=%b exp y=1 beats=1 v=1", bi.y, bi.beats, bi.out_valid); end
    tick();
  endtask
  task automatic test_saturation;
    bs.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bs.in_valid = 1'b1; bs.op = 3'b111; bs.a = 32'hFFFF_FFFF; bs.b = 32'h0; bs.last = (i == 1);
      tick();
    end
    bs.in_valid = 1'b0;
    n_chk++; if (bs.beats !== 2'd2) begin n_fail++; $display("FAIL sat_two got %0d exp 2", bs.beats); end
    for (int i = 0; i < 6; i++) begin
      bs.in_valid = 1'b1; bs.op = 3'b111; bs.a = 32'hFFFF_FFFF; bs.b = 32'h0; bs.last = (i == 5);
      tick();
    end
    bs.in_valid = 1'b0;
    n_chk++; if (bs.beats !== 2'd3) begin n_fail++; $display("FAIL sat_beats got %0d exp 3", bs.beats); end
    n_chk++; if (bs.y !== 32'hFFFF_FFFF || bs.out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_y got y=%h v=%b exp y=ffffffff v=1", bs.y, bs.out_valid); end
    tick();
  endtask
`ifdef LOGIC_UNIT_POPCNT_EN
  task automatic test_popcnt;
    bi.out_ready = 1'b1;
    drive(1'b1, 3'b010, 32'hFFFF_0000, 32'h00FF_0000, 1'b1);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    n_chk++; if (bi.y !== 32'hFF00_0000) begin n_fail++; $display("FAIL pc_y got %h exp ff000000", bi.y); end
    n_chk++; if (bi.popcnt !== 6'd8) begin n_fail++; $display("FAIL pc_count got %0d exp 8", bi.popcnt); end
    tick();
  endtask
`endif
  initial begin
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    bi.out_ready = 1'b0;
    bs.in_valid = 1'b0; bs.op = 3'b000; bs.a = 32'h0; bs.b = 32'h0; bs.last = 1'b0; bs.out_ready = 1'b0;
    test_reset();
    test_single();
    test_imp_packet();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    test_saturation();
`ifdef LOGIC_UNIT_POPCNT_EN
    test_popcnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
